// File: rtl/axi_lite_sram.sv
// axi_lite_sram
//   AXI-lite slave backed by a word-addressed on-chip memory. The read and
//   write channels each have their own FSM and run fully in parallel. Every
//   transaction waits L cycles before its response is presented. L is either
//   FIXED_LAT or lfsr[3:0] and is sampled in the cycle the transaction is
//   accepted.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
//
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid and ready are both 1. Once the slave raises a valid, it holds
// that valid and its payload stable until the matching ready is seen. The
// slave's readys do not depend on the master's valids, and all readys and
// valids read 0 while rst_n is low.
//
// Responses: 2'b00 OKAY for an in-range address, 2'b11 DECERR otherwise.
// An out-of-range read returns data 0. An out-of-range write changes nothing.
module axi_lite_sram #(
  parameter int          MEM_DEPTH = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          LAT_MODE  = 0,
  parameter int          FIXED_LAT = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  r_state_t r_state, r_state_d;
  w_state_t w_state, w_state_d;

  logic [31:0] mem [MEM_DEPTH];

  // Byte lanes inside a word are selected only by wstrb, so the low address
  // bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

  // ---------------------------------------------------------------------------
  // Latency source: 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
  // ---------------------------------------------------------------------------
  logic [7:0] lfsr;
  logic [3:0] lat_now;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_now = (LAT_MODE != 0) ? lfsr[3:0] : 4'(FIXED_LAT);

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [29:0]      ar_word_q;
  logic [29:0]      r_word;
  logic [29:0]      r_off;
  logic             r_in;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       rcnt, rcnt_d;
  logic             ar_take;
  logic             r_load;
  logic [31:0]      r_next_data;

  assign arready = rst_n & (r_state == R_IDLE);
  assign rvalid  = rst_n & (r_state == R_DATA);
  assign ar_take = arvalid & arready;

  // In R_IDLE with L = 0 the data is loaded on the acceptance edge, so the
  // address is taken straight from the bus instead of the latch.
  assign r_word = (r_state == R_IDLE) ? araddr[31:2] : ar_word_q;
  assign r_off  = r_word - BASE_ADDR[31:2];
  assign r_in   = ({1'b0, r_off} < 31'(MEM_DEPTH));
  assign r_idx  = r_off[IDX_W-1:0];

  assign r_load = ((r_state == R_IDLE) && ar_take && (lat_now == 4'd0)) ||
                  ((r_state == R_WAIT) && (rcnt == 4'd1));

  always_comb begin
    r_state_d = r_state;
    rcnt_d    = rcnt;
    case (r_state)
      R_IDLE: begin
        if (ar_take) begin
          rcnt_d    = lat_now;
          r_state_d = (lat_now == 4'd0) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt == 4'd1) r_state_d = R_DATA;
        else              rcnt_d    = rcnt - 4'd1;
      end
      R_DATA: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic             aw_held, w_held;
  logic [29:0]      aw_word_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_take, w_take, both_now;
  logic [29:0]      w_word;
  logic [31:0]      w_data_eff;
  logic [3:0]       w_strb_eff;
  logic [29:0]      w_off;
  logic             w_in;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       wcnt, wcnt_d;
  logic             w_commit, commit_ok;

  assign awready  = rst_n & (w_state == W_IDLE) & ~aw_held;
  assign wready   = rst_n & (w_state == W_IDLE) & ~w_held;
  assign bvalid   = rst_n & (w_state == W_RESP);
  assign aw_take  = awvalid & awready;
  assign w_take   = wvalid & wready;
  assign both_now = (aw_held | aw_take) & (w_held | w_take);

  // When L = 0 the commit happens on the same edge that captures the last
  // channel, so whichever half is not yet held comes directly from the bus.
  assign w_word     = aw_held ? aw_word_q : awaddr[31:2];
  assign w_data_eff = w_held  ? wdata_q   : wdata;
  assign w_strb_eff = w_held  ? wstrb_q   : wstrb;
  assign w_off      = w_word - BASE_ADDR[31:2];
  assign w_in       = ({1'b0, w_off} < 31'(MEM_DEPTH));
  assign w_idx      = w_off[IDX_W-1:0];

  assign w_commit  = ((w_state == W_IDLE) && both_now && (lat_now == 4'd0)) ||
                     ((w_state == W_WAIT) && (wcnt == 4'd1));
  // A reset on the commit edge abandons the write.
  assign commit_ok = rst_n & w_commit & w_in;

  always_comb begin
    w_state_d = w_state;
    wcnt_d    = wcnt;
    case (w_state)
      W_IDLE: begin
        if (both_now) begin
          wcnt_d    = lat_now;
          w_state_d = (lat_now == 4'd0) ? W_RESP : W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt == 4'd1) w_state_d = W_RESP;
        else              wcnt_d    = wcnt - 4'd1;
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read data with write-first bypass: a write committing on the same edge
  // that loads rdata overrides the stale memory bytes it touches.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_next_data = mem[r_idx];
    for (int b = 0; b < 4; b++) begin
      if (commit_ok && (w_idx == r_idx) && w_strb_eff[b])
        r_next_data[b*8 +: 8] = w_data_eff[b*8 +: 8];
    end
    if (!r_in) r_next_data = 32'h0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      rcnt      <= 4'd0;
      ar_word_q <= 30'd0;
      rdata     <= 32'h0;
      rresp     <= 2'b00;
    end else begin
      r_state <= r_state_d;
      rcnt    <= rcnt_d;
      if (ar_take) ar_word_q <= araddr[31:2];
      if (r_load) begin
        rdata <= r_next_data;
        rresp <= r_in ? 2'b00 : 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      wcnt      <= 4'd0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_word_q <= 30'd0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bresp     <= 2'b00;
    end else begin
      w_state <= w_state_d;
      wcnt    <= wcnt_d;
      if (aw_take) begin
        aw_held   <= 1'b1;
        aw_word_q <= awaddr[31:2];
      end
      if (w_take) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_commit) bresp <= w_in ? 2'b00 : 2'b11;
      if ((w_state == W_RESP) && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_eff[b]) mem[w_idx][b*8 +: 8] <= w_data_eff[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb_axi_lite_sram
//   Directed bench for axi_lite_sram. Two instances share one set of driven
//   inputs: u_fix (LAT_MODE=0, FIXED_LAT=1) and u_rnd (LAT_MODE=1). The
//   signal sel selects which instance sees the valids and readys and which
//   outputs are observed. Inputs change and outputs are sampled 1 ns after
//   each rising edge.
module tb_axi_lite_sram;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic sel;

  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;

  logic        arready0, rvalid0, awready0, wready0, bvalid0;
  logic        arready1, rvalid1, awready1, wready1, bvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1, bresp0, bresp1;

  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  assign arready = sel ? arready1 : arready0;
  assign rvalid  = sel ? rvalid1  : rvalid0;
  assign awready = sel ? awready1 : awready0;
  assign wready  = sel ? wready1  : wready0;
  assign bvalid  = sel ? bvalid1  : bvalid0;
  assign rdata   = sel ? rdata1   : rdata0;
  assign rresp   = sel ? rresp1   : rresp0;
  assign bresp   = sel ? bresp1   : bresp0;

  axi_lite_sram #(.LAT_MODE(0), .FIXED_LAT(1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid & ~sel), .arready(arready0),
    .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(rready & ~sel),
    .awaddr(awaddr), .awvalid(awvalid & ~sel), .awready(awready0),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & ~sel), .wready(wready0),
    .bresp(bresp0), .bvalid(bvalid0), .bready(bready & ~sel)
  );

  axi_lite_sram #(.LAT_MODE(1)) u_rnd (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid & sel), .arready(arready1),
    .rdata(rdata1), .rresp(rresp1), .rvalid(rvalid1), .rready(rready & sel),
    .awaddr(awaddr), .awvalid(awvalid & sel), .awready(awready1),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel), .wready(wready1),
    .bresp(bresp1), .bvalid(bvalid1), .bready(bready & sel)
  );

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write one transaction. skew > 0 sends W skew cycles before AW; skew < 0
  // sends AW first. lat counts the edges after the last capture edge until
  // bvalid is seen. exp_l is the reference LFSR nibble in the capture cycle.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int skew, input int bdly,
                          output logic [1:0] resp, output int lat,
                          output logic [3:0] exp_l, output bit ok);
    int cyc;
    bit aw_done, w_done, hs_aw, hs_w;
    cyc = 0; aw_done = 0; w_done = 0; ok = 1; lat = 0; resp = 2'bxx; exp_l = 4'h0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (cyc >= ((skew < 0) ? 0 : skew));
      wvalid  = !w_done  && (cyc >= ((skew < 0) ? -skew : 0));
      hs_aw = awvalid & awready;
      hs_w  = wvalid & wready;
      if ((aw_done | hs_aw) & (w_done | hs_w)) exp_l = m_lfsr[3:0];
      step();
      aw_done |= hs_aw;
      w_done  |= hs_w;
      cyc++;
      if (cyc > 60) begin
        awvalid = 0; wvalid = 0; ok = 0;
        return;
      end
    end
    awvalid = 0; wvalid = 0;
    while (!bvalid && lat < 40) begin step(); lat++; end
    if (!bvalid) begin ok = 0; return; end
    resp = bresp;
    repeat (bdly) step();
    bready = 1;
    step();
    bready = 0;
  endtask

  // Read one transaction. stable reports that rvalid, rdata and rresp held
  // and arready stayed low while rready was withheld for rdly cycles.
  task automatic do_read(input logic [31:0] addr, input int rdly,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output logic [3:0] exp_l,
                         output bit ok, output bit stable);
    int cyc;
    cyc = 0; ok = 1; stable = 1; lat = 0; data = 'x; resp = 'x; exp_l = 4'h0;
    araddr = addr; arvalid = 1;
    while (!arready && cyc < 60) begin step(); cyc++; end
    if (!arready) begin arvalid = 0; ok = 0; return; end
    exp_l = m_lfsr[3:0];
    step();
    arvalid = 0;
    while (!rvalid && lat < 40) begin step(); lat++; end
    if (!rvalid) begin ok = 0; return; end
    data = rdata; resp = rresp;
    repeat (rdly) begin
      step();
      if (!rvalid || rdata !== data || rresp !== resp || arready) stable = 0;
    end
    rready = 1;
    step();
    rready = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 0; sel = 0;
    arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = 0; awaddr = 0; wdata = 0; wstrb = 0;
    repeat (3) step();
    checks++; if ({rvalid0, bvalid0, rvalid1, bvalid1} !== 4'b0) begin failures++; $display("FAIL reset_valids: got %b expected 0000", {rvalid0, bvalid0, rvalid1, bvalid1}); end
    checks++; if ({arready0, awready0, wready0, arready1, awready1, wready1} !== 6'b0) begin failures++; $display("FAIL reset_readys: got %b expected 000000", {arready0, awready0, wready0, arready1, awready1, wready1}); end
    checks++; if ({rdata0, rresp0, bresp0} !== 36'h0) begin failures++; $display("FAIL reset_payload: got %h expected 0", {rdata0, rresp0, bresp0}); end
    rst_n = 1;
    step();
    checks++; if ({arready0, awready0, wready0, arready1, awready1, wready1} !== 6'b111111) begin failures++; $display("FAIL release_readys: got %b expected 111111", {arready0, awready0, wready0, arready1, awready1, wready1}); end
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [31:0] d; int lat; logic [3:0] el; bit ok, st;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, lat, el, ok);
    checks++; if (!ok || lat != 1) begin failures++; $display("FAIL wr_latency: got ok=%0d lat=%0d expected lat=1", ok, lat); end
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL wr_bresp: got %b expected 00", resp); end
    do_read(32'h8000_0010, 0, d, resp, lat, el, ok, st);
    checks++; if (!ok || lat != 1) begin failures++; $display("FAIL rd_latency: got ok=%0d lat=%0d expected lat=1", ok, lat); end
    checks++; if (d !== 32'hDEAD_BEEF || resp !== 2'b00) begin failures++; $display("FAIL rd_data: got %h/%b expected deadbeef/00", d, resp); end
  endtask

  task automatic test_partial();
    logic [1:0] resp; logic [31:0] d; int lat; logic [3:0] el; bit ok, st;
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 3, 1, resp, lat, el, ok);
    checks++; if (!ok || resp !== 2'b00) begin failures++; $display("FAIL partial_bresp: got ok=%0d %b expected 00", ok, resp); end
    do_read(32'h8000_0010, 0, d, resp, lat, el, ok, st);
    checks++; if (d !== 32'hDE22_BE44) begin failures++; $display("FAIL partial_data: got %h expected de22be44", d); end
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, -1, 0, resp, lat, el, ok);
    checks++; if (!ok || resp !== 2'b00) begin failures++; $display("FAIL zero_strb_bresp: got ok=%0d %b expected 00", ok, resp); end
    do_read(32'h8000_0013, 0, d, resp, lat, el, ok, st);
    checks++; if (d !== 32'hDE22_BE44) begin failures++; $display("FAIL zero_strb_data: got %h expected de22be44", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; int lat; logic [3:0] el; bit ok, st;
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, resp, lat, el, ok);
    do_read(32'h7FFF_FFFC, 0, d, resp, lat, el, ok, st);
    checks++; if (!ok || d !== 32'h0 || resp !== 2'b11) begin failures++; $display("FAIL oor_read: got %h/%b expected 00000000/11", d, resp); end
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, -2, 0, resp, lat, el, ok);
    checks++; if (!ok || resp !== 2'b11) begin failures++; $display("FAIL oor_write: got %b expected 11", resp); end
    do_read(32'h8000_0000, 0, d, resp, lat, el, ok, st);
    checks++; if (d !== 32'hCAFE_F00D || resp !== 2'b00) begin failures++; $display("FAIL oor_no_alias: got %h/%b expected cafef00d/00", d, resp); end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [31:0] d; int lat; logic [3:0] el; bit ok, st;
    do_read(32'h8000_0010, 5, d, resp, lat, el, ok, st);
    checks++; if (!ok || !st) begin failures++; $display("FAIL bp_stable: got ok=%0d stable=%0d expected 1/1", ok, st); end
    checks++; if (d !== 32'hDE22_BE44) begin failures++; $display("FAIL bp_data: got %h expected de22be44", d); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_single: got rvalid=%b expected 0", rvalid); end
  endtask

  // AW, W and AR to the same word accepted on the same edge with L = 1:
  // the read loads on the write commit edge and must see the new data.
  task automatic test_bypass();
    logic [1:0] resp; int lat; logic [3:0] el; bit ok;
    do_write(32'h8000_0020, 32'h0101_0101, 4'hF, 0, 0, resp, lat, el, ok);
    awaddr = 32'h8000_0020; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    araddr = 32'h8000_0020;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1) begin failures++; $display("FAIL bypass_valids: got r=%b b=%b expected 1/1", rvalid, bvalid); end
    checks++; if (rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bypass_data: got %h expected a5a5a5a5", rdata); end
    rready = 1; bready = 1;
    step();
    rready = 0; bready = 0;
  endtask

  task automatic test_random();
    logic [31:0] sb_mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] addr, data, d, e;
    logic [3:0]  strb, el;
    logic [1:0]  resp;
    int lat, i;
    bit ok, st, oor;
    sel = 1;
    for (int k = 0; k < 16; k++) begin
      data = $urandom;
      do_write(32'h8000_0100 + 32'(4 * k), data, 4'hF, 0, 0, resp, lat, el, ok);
      sb_mem[k] = data;
      checks++; if (!ok || resp !== 2'b00 || lat != int'(el)) begin failures++; $display("FAIL rnd_init[%0d]: got ok=%0d resp=%b lat=%0d expected 00 lat=%0d", k, ok, resp, lat, el); end
    end
    for (int n = 0; n < 200; n++) begin
      i = $urandom_range(0, 15);
      oor = ($urandom_range(0, 7) == 0);
      if (oor) addr = ($urandom_range(0, 1) == 1) ? 32'h8000_4000 + 32'(4 * i) : 32'h7FFF_FF00 + 32'(4 * i);
      else     addr = 32'h8000_0100 + 32'(4 * i);
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 6) - 3, $urandom_range(0, 3), resp, lat, el, ok);
        if (!oor)
          for (int b = 0; b < 4; b++) if (strb[b]) sb_mem[i][b*8 +: 8] = data[b*8 +: 8];
        checks++; if (!ok || resp !== (oor ? 2'b11 : 2'b00) || lat != int'(el)) begin failures++; $display("FAIL rnd_wr[%0d]: got ok=%0d resp=%b lat=%0d expected resp=%b lat=%0d", n, ok, resp, lat, oor ? 2'b11 : 2'b00, el); end
      end else begin
        exp_q.push_back(oor ? 32'h0 : sb_mem[i]);
        do_read(addr, $urandom_range(0, 3), d, resp, lat, el, ok, st);
        e = exp_q.pop_front();
        checks++; if (!ok || d !== e || resp !== (oor ? 2'b11 : 2'b00)) begin failures++; $display("FAIL rnd_rd[%0d]: got ok=%0d %h/%b expected %h/%b", n, ok, d, resp, e, oor ? 2'b11 : 2'b00); end
        checks++; if (lat != int'(el) || !st) begin failures++; $display("FAIL rnd_rd_lat[%0d]: got lat=%0d stable=%0d expected lat=%0d", n, lat, st, el); end
      end
    end
    sel = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    araddr = 32'h8000_0010; arvalid = 1;
    step();                       // accepted, read now in R_WAIT
    arvalid = 0;
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    rready = 1;
    repeat (10) begin step(); if (rvalid) seen = 1; end
    rready = 0;
    checks++; if (seen) begin failures++; $display("FAIL reset_mid_rvalid: got rvalid=1 expected 0"); end
    checks++; if (arready !== 1'b1) begin failures++; $display("FAIL reset_mid_idle: got arready=%b expected 1", arready); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_backpressure();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
